// File: rtl/flush_arbiter.sv
// flush_arbiter: priority flush arbitration for the core front end.
// Source 0 has the highest priority. The winning request kills the pipeline in
// the same cycle and its target is held as a redirect until IF accepts it.
// Optional build macro: ZCRV_FLUSH_CNT_EN enables the saturating accepted-redirect
// counter on flush_cnt. Without it, flush_cnt is tied to zero.

`ifndef ZCRV_ADDR_SIZE
`define ZCRV_ADDR_SIZE 32
`endif

module flush_arbiter #(
  parameter int ADDR_W = `ZCRV_ADDR_SIZE,
  parameter int NSRC   = 4,
  parameter int SRC_W  = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC-1:0]        flush_req,
  input  logic [NSRC*ADDR_W-1:0] flush_addr,
  output logic                   flush_to_pipeline,
  output logic [ADDR_W-1:0]      flush_pc_comb,
  output logic                   redir_valid,
  input  logic                   redir_ready,
  output logic [ADDR_W-1:0]      redir_pc,
  output logic [SRC_W-1:0]       redir_src,
  output logic [31:0]            flush_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e              state_q;
  logic                redir_valid_q;
  logic [ADDR_W-1:0]   redir_pc_q;
  logic [SRC_W-1:0]    redir_src_q;

  logic                any_req;
  logic [SRC_W-1:0]    win;
  logic [ADDR_W-1:0]   win_pc;
  logic                handshake;

  // Priority pick: scan from the lowest priority upward so index 0 wins last.
  always_comb begin
    any_req = |flush_req;
    win     = '0;
    win_pc  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (flush_req[i]) begin
        win    = SRC_W'(i);
        win_pc = flush_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign flush_to_pipeline = any_req;
  assign flush_pc_comb     = win_pc;
  assign handshake         = redir_valid_q & redir_ready;

  // Redirect FSM; lower-priority requests during PEND are dropped because the
  // pending flush already kills the instructions that raised them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      redir_src_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q       <= PEND;
            redir_valid_q <= 1'b1;
            redir_pc_q    <= win_pc;
            redir_src_q   <= win;
          end
        end
        PEND: begin
          if (any_req && (win <= redir_src_q)) begin
            redir_pc_q  <= win_pc;
            redir_src_q <= win;
          end else if (redir_ready) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          redir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign redir_src   = redir_src_q;

`ifdef ZCRV_FLUSH_CNT_EN
  logic [31:0] flush_cnt_q;

  // Saturating count of completed redirect handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
    end else if (handshake && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign flush_cnt = flush_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = handshake;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_flush_arbiter.sv
// Bench for flush_arbiter: a table of per-cycle vectors with hand-derived expected
// outputs, plus a reset sequence in the middle of a pending redirect.
`timescale 1ns/1ps

module tb_flush_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   flush_req;
  logic [127:0] flush_addr;
  logic         flush_to_pipeline;
  logic [31:0]  flush_pc_comb;
  logic         redir_valid;
  logic         redir_ready;
  logic [31:0]  redir_pc;
  logic [1:0]   redir_src;
  logic [31:0]  flush_cnt;

  flush_arbiter #(.ADDR_W(32), .NSRC(4), .SRC_W(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_req         (flush_req),
    .flush_addr        (flush_addr),
    .flush_to_pipeline (flush_to_pipeline),
    .flush_pc_comb     (flush_pc_comb),
    .redir_valid       (redir_valid),
    .redir_ready       (redir_ready),
    .redir_pc          (redir_pc),
    .redir_src         (redir_src),
    .flush_cnt         (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   req;
    logic [127:0] addr;
    logic         rdy;
    logic         kill;
    logic [31:0]  pc_comb;
    logic         valid;
    logic [31:0]  pc;
    logic [1:0]   src;
    logic         hs;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  src;
  } exp_t;

  exp_t   sb_q[$];
  vec_t   tbl[16];
  int     n_chk;
  int     n_err;
  int     exp_cnt;

  function automatic logic [127:0] ad(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic [3:0] req, input logic [127:0] addr,
                              input logic rdy, input logic kill,
                              input logic [31:0] pc_comb, input logic valid,
                              input logic [31:0] pc, input logic [1:0] src,
                              input logic hs);
    vec_t v;
    v.req = req; v.addr = addr; v.rdy = rdy; v.kill = kill; v.pc_comb = pc_comb;
    v.valid = valid; v.pc = pc; v.src = src; v.hs = hs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp();
`ifdef ZCRV_FLUSH_CNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Drive one vector just after a rising edge, check the combinational outputs,
  // queue the registered expectation, then check it after the next edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    flush_req   = v.req;
    flush_addr  = v.addr;
    redir_ready = v.rdy;
    #1;
    chk({name, ".kill"}, {31'd0, flush_to_pipeline}, {31'd0, v.kill});
    chk({name, ".pc_comb"}, flush_pc_comb, v.pc_comb);
    e.valid = v.valid; e.pc = v.pc; e.src = v.src;
    sb_q.push_back(e);
    if (v.hs) exp_cnt++;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s.scoreboard: got empty queue, expected one entry", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".valid"}, {31'd0, redir_valid}, {31'd0, e.valid});
      if (e.valid) begin
        chk({name, ".redir_pc"}, redir_pc, e.pc);
        chk({name, ".redir_src"}, {30'd0, redir_src}, {30'd0, e.src});
      end
    end
    chk({name, ".flush_cnt"}, flush_cnt, cnt_exp());
  endtask

  initial begin
    vec_t idle;
    n_chk = 0; n_err = 0; exp_cnt = 0;
    rst_n = 1'b0; flush_req = '0; flush_addr = '0; redir_ready = 1'b0;

    idle = mk(4'b0000, '0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0);
    //            req      addr (a0,a1,a2,a3)                               rdy   kill  pc_comb       valid pc            src  hs
    tbl[0]  = mk(4'b0010, ad(32'h6000, 32'h1000, 32'h4000, 32'h5000), 1'b0, 1'b1, 32'h1000, 1'b1, 32'h1000, 2'd1, 1'b0);
    tbl[1]  = mk(4'b0000, ad(32'h6000, 32'h1000, 32'h4000, 32'h5000), 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    2'd0, 1'b1);
    tbl[2]  = mk(4'b1010, ad(32'h6000, 32'h2000, 32'h4000, 32'h3000), 1'b0, 1'b1, 32'h2000, 1'b1, 32'h2000, 2'd1, 1'b0);
    tbl[3]  = mk(4'b0000, ad(32'h6000, 32'h2000, 32'h4000, 32'h3000), 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    2'd0, 1'b1);
    tbl[4]  = mk(4'b0100, ad(32'h6000, 32'h1000, 32'h4000, 32'h5000), 1'b0, 1'b1, 32'h4000, 1'b1, 32'h4000, 2'd2, 1'b0);
    tbl[5]  = mk(4'b1000, ad(32'h6000, 32'h1000, 32'h4000, 32'h5000), 1'b0, 1'b1, 32'h5000, 1'b1, 32'h4000, 2'd2, 1'b0);
    tbl[6]  = mk(4'b0000, ad(32'h6000, 32'h1000, 32'h4000, 32'h5000), 1'b0, 1'b0, 32'h0,    1'b1, 32'h4000, 2'd2, 1'b0);
    tbl[7]  = mk(4'b0001, ad(32'h6000, 32'h1000, 32'h4000, 32'h5000), 1'b0, 1'b1, 32'h6000, 1'b1, 32'h6000, 2'd0, 1'b0);
    tbl[8]  = mk(4'b0010, ad(32'h6000, 32'h1000, 32'h4000, 32'h5000), 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0,    2'd0, 1'b1);
    tbl[9]  = mk(4'b0010, ad(32'h6000, 32'h7000, 32'h4000, 32'h5000), 1'b1, 1'b1, 32'h7000, 1'b1, 32'h7000, 2'd1, 1'b0);
    tbl[10] = mk(4'b0010, ad(32'h6000, 32'h8000, 32'h4000, 32'h5000), 1'b1, 1'b1, 32'h8000, 1'b1, 32'h8000, 2'd1, 1'b1);
    tbl[11] = mk(4'b0010, ad(32'h6000, 32'h9000, 32'h4000, 32'h5000), 1'b0, 1'b1, 32'h9000, 1'b1, 32'h9000, 2'd1, 1'b0);
    tbl[12] = mk(4'b0111, ad(32'hA000, 32'h9000, 32'h4000, 32'h5000), 1'b0, 1'b1, 32'hA000, 1'b1, 32'hA000, 2'd0, 1'b0);
    tbl[13] = mk(4'b0000, ad(32'hA000, 32'h9000, 32'h4000, 32'h5000), 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    2'd0, 1'b1);
    tbl[14] = mk(4'b0000, ad(32'hA000, 32'h9000, 32'h4000, 32'h5000), 1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    2'd0, 1'b0);
    tbl[15] = mk(4'b0100, ad(32'hA000, 32'h9000, 32'hB000, 32'h5000), 1'b0, 1'b1, 32'hB000, 1'b1, 32'hB000, 2'd2, 1'b0);

    #1;
    chk("rst.valid", {31'd0, redir_valid}, 32'd0);
    chk("rst.redir_pc", redir_pc, 32'h0);
    chk("rst.redir_src", {30'd0, redir_src}, 32'd0);
    chk("rst.flush_cnt", flush_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) apply(idle, "idle");

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of the cycle while a redirect is pending.
    #2;
    rst_n = 1'b0;
    flush_req  = 4'b0001;
    flush_addr = ad(32'hC000, 32'h0, 32'h0, 32'h0);
    #1;
    chk("arst.valid", {31'd0, redir_valid}, 32'd0);
    chk("arst.redir_pc", redir_pc, 32'h0);
    chk("arst.redir_src", {30'd0, redir_src}, 32'd0);
    chk("arst.flush_cnt", flush_cnt, 32'd0);
    chk("arst.kill", {31'd0, flush_to_pipeline}, 32'd1);
    chk("arst.pc_comb", flush_pc_comb, 32'hC000);
    exp_cnt = 0;
    flush_req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply(mk(4'b0000, '0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0), "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
